// File: rtl/biriscv_inst_queue_pkg.sv
// Shared types for the instruction queue: stored packet layout and slot-valid mask helper.
// Optional macro BIRISCV_IQ_BYPASS_EN is consumed by biriscv_inst_queue.sv.
package biriscv_inst_queue_pkg;

    typedef struct packed {
        logic        fault_page;
        logic        fault_fetch;
        logic [1:0]  pred;
        logic [28:0] pc_hi;
        logic [63:0] instr;
    } iq_entry_t;

    localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

    // Slot0 is skipped when the packet starts at the upper word; slot1 is dropped when
    // slot0 is a predicted-taken branch.
    function automatic logic [1:0] slot_mask(input logic pc2, input logic pred0);
        logic v0;
        v0 = ~pc2;
        return {~(v0 & pred0), v0};
    endfunction

endpackage

// File: rtl/biriscv_iq_ram.sv
// Packet storage for the instruction queue: DEPTH x WIDTH registers, one write port and one
// asynchronous read port.
module biriscv_iq_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/biriscv_inst_queue.sv
// Fetch-to-issue instruction queue presenting up to two in-order lanes from the head packet.
// Define BIRISCV_IQ_BYPASS_EN to let a packet arriving at an empty queue drive the lanes directly.
module biriscv_inst_queue
    import biriscv_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [63:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [1:0]  fetch_pred_branch_i,
    input  logic        fetch_fault_fetch_i,
    input  logic        fetch_fault_page_i,
    output logic        fetch_accept_o,
    output logic        inst0_valid_o,
    output logic [31:0] inst0_instr_o,
    output logic [31:0] inst0_pc_o,
    output logic        inst0_pred_taken_o,
    output logic        inst0_fault_fetch_o,
    output logic        inst0_fault_page_o,
    output logic        inst1_valid_o,
    output logic [31:0] inst1_instr_o,
    output logic [31:0] inst1_pc_o,
    output logic        inst1_pred_taken_o,
    output logic        inst1_fault_fetch_o,
    output logic        inst1_fault_page_o,
    input  logic        inst0_accept_i,
    input  logic        inst1_accept_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_mask [DEPTH];

    iq_entry_t  w_head;
    iq_entry_t  w_in;
    iq_entry_t  w_src;
    logic [1:0] w_in_mask;
    logic [1:0] w_src_mask;
    logic [1:0] w_cons;
    logic [1:0] w_rem;
    logic [1:0] w_wr_mask;
    logic       w_empty;
    logic       w_bypass;
    logic       w_push;
    logic       w_write;
    logic       w_pop;
    logic       w_l0_valid;
    logic       w_l0_slot;
    logic       w_l1_valid;
    logic       w_unused_pc_lo;

    assign w_unused_pc_lo = ^fetch_pc_i[1:0];
    assign fetch_accept_o = (r_count != CNT_W'(DEPTH));

    biriscv_iq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (IQ_ENTRY_W)
    ) u_ram (
        .i_clk     (clk_i),
        .i_wr_en   (w_write),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    always_comb begin
        w_in.instr       = fetch_instr_i;
        w_in.pc_hi       = fetch_pc_i[31:3];
        w_in.pred        = fetch_pred_branch_i;
        w_in.fault_fetch = fetch_fault_fetch_i;
        w_in.fault_page  = fetch_fault_page_i;
        w_in_mask        = slot_mask(fetch_pc_i[2], fetch_pred_branch_i[0]);
        w_empty          = (r_count == '0);
`ifdef BIRISCV_IQ_BYPASS_EN
        w_bypass         = w_empty & fetch_valid_i & ~flush_i;
`else
        w_bypass         = 1'b0;
`endif
        w_src            = w_bypass ? w_in : w_head;
        w_src_mask       = w_bypass ? w_in_mask : (w_empty ? 2'b00 : r_mask[r_rd_ptr]);

        w_l0_valid = |w_src_mask;
        w_l0_slot  = ~w_src_mask[0];
        w_l1_valid = &w_src_mask;

        w_cons = 2'b00;
        if (!flush_i && inst0_accept_i && w_l0_valid) begin
            w_cons[w_l0_slot] = 1'b1;
            if (inst1_accept_i && w_l1_valid) begin
                w_cons[1] = 1'b1;
            end
        end
        w_rem = w_src_mask & ~w_cons;

        // In bypass a fully consumed packet never needs storing.
        w_push    = fetch_valid_i & fetch_accept_o & ~flush_i;
        w_write   = w_push & (~w_bypass | (w_rem != 2'b00));
        w_wr_mask = w_bypass ? w_rem : w_in_mask;
        w_pop     = ~flush_i & ~w_bypass & (w_src_mask != 2'b00) & (w_rem == 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mask[i] <= 2'b00;
            end
        end else begin
            if (!w_bypass && !w_empty) begin
                r_mask[r_rd_ptr] <= w_rem;
            end
            if (w_write) begin
                r_mask[r_wr_ptr] <= w_wr_mask;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_pop);
        end
    end

    always_comb begin
        inst0_valid_o       = w_l0_valid;
        inst0_instr_o       = '0;
        inst0_pc_o          = '0;
        inst0_pred_taken_o  = 1'b0;
        inst0_fault_fetch_o = 1'b0;
        inst0_fault_page_o  = 1'b0;
        inst1_valid_o       = w_l1_valid;
        inst1_instr_o       = '0;
        inst1_pc_o          = '0;
        inst1_pred_taken_o  = 1'b0;
        inst1_fault_fetch_o = 1'b0;
        inst1_fault_page_o  = 1'b0;
        if (w_l0_valid) begin
            inst0_instr_o       = w_l0_slot ? w_src.instr[63:32] : w_src.instr[31:0];
            inst0_pc_o          = {w_src.pc_hi, w_l0_slot, 2'b00};
            inst0_pred_taken_o  = w_src.pred[w_l0_slot];
            inst0_fault_fetch_o = w_src.fault_fetch;
            inst0_fault_page_o  = w_src.fault_page;
        end
        if (w_l1_valid) begin
            inst1_instr_o       = w_src.instr[63:32];
            inst1_pc_o          = {w_src.pc_hi, 1'b1, 2'b00};
            inst1_pred_taken_o  = w_src.pred[1];
            inst1_fault_fetch_o = w_src.fault_fetch;
            inst1_fault_page_o  = w_src.fault_page;
        end
    end

endmodule
